switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
//
// PURPOSE
//   Conditions the raw board slide switches before they reach the CPU's memory-mapped switch input.
//   - Per bit: 2-flop synchroniser, then a stability-counter debouncer.
//   - Outputs a clean, glitch-free switch vector, plus a one-cycle change pulse per bit.
//   Sits between the board pins and the CPU's 8-bit switches input, in the same clk domain.
//
// PARAMETERS
//   WIDTH          8        number of switch bits conditioned
//   STABLE_CYCLES  1000000  consecutive mismatch cycles required to accept a new level (10 ms @ 100 MHz); must be >= 1
//   CNT_W          20       per-bit counter width; must satisfy 2**CNT_W >= STABLE_CYCLES
//
// PORTS
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   sw_raw       in   WIDTH  asynchronous switch pins
//   sw_clean     out  WIDTH  debounced level; drives CPU switches
//   sw_changed   out  WIDTH  one-cycle pulse on the bit whose sw_clean just updated
//   any_changed  out  1      registered OR of all sw_changed bits, in the same cycle
//
// BEHAVIOUR
//   Reset
//   - rst_n low clears immediately, with no clock needed: s1, s2, sw_clean, per-bit counters, sw_changed and any_changed.
//   - Reset asserted mid-count discards progress.
//   - After rst_n rises, switches that are high are accepted through the normal debounce path.
//   Synchroniser
//   - Each edge: s1 <= sw_raw; s2 <= s1.
//   - Only s2 feeds the debounce logic.
//   Per-bit debounce, on each rising edge, bit i:
//   - s2[i] == sw_clean[i]: cnt[i] <= 0; sw_changed[i] <= 0.
//   - s2[i] != sw_clean[i] and cnt[i] == STABLE_CYCLES-1: sw_clean[i] <= s2[i]; cnt[i] <= 0; sw_changed[i] <= 1.
//   - s2[i] != sw_clean[i] otherwise: cnt[i] <= cnt[i]+1; sw_changed[i] <= 0.
//   Latency
//   - A clean raw transition appears on sw_clean STABLE_CYCLES+2 rising edges after the first edge that samples it.
//   - sw_changed[i] and any_changed are high for exactly the cycle following that edge.
//   Glitch rejection
//   - Any return of s2[i] to sw_clean[i] before the count completes zeroes cnt[i].
//   - A mismatch run shorter than STABLE_CYCLES cycles never reaches sw_clean.
//   Bit independence
//   - Bits never share counters.
//   - Simultaneous acceptance on several bits pulses all of them in the same cycle.
//   Counter bound
//   - cnt[i] never exceeds STABLE_CYCLES-1, so there is no wrap-around.
//   - STABLE_CYCLES == 1 accepts a level after one mismatch cycle (latency 3).
//   Outputs
//   - All outputs are registered; there are no combinational paths from sw_raw.
//
// TESTING  (bench uses STABLE_CYCLES=4, WIDTH=8)
//   1. Reset: rst_n=0 with sw_raw=8'hFF, no clock.
//      -> sw_clean=8'h00, sw_changed=0, any_changed=0 immediately.
//   2. Clean step: sw_raw 8'h00 -> 8'h01 held.
//      -> sw_clean=8'h01 exactly 6 edges after the first sampling edge.
//      -> sw_changed=8'h01 and any_changed=1 for one cycle, then 0.
//   3. Bounce: bit 3 toggles high for 3 cycles, low for 1, then high steady.
//      -> no update during the bounce.
//      -> sw_clean[3]=1 six edges after the last rising transition.
//      -> single sw_changed[3] pulse.
//   4. Short glitch: bit 7 high for 3 cycles only.
//      -> sw_clean stays 8'h00; sw_changed never asserts.
//   5. Simultaneous: sw_raw 8'h00 -> 8'hA5 in one edge.
//      -> sw_clean=8'hA5 at the same edge for all bits; sw_changed=8'hA5 for one cycle.
//   6. Reset mid-count: bit 0 mismatch for 2 cycles, then rst_n pulse low with bit 0 still high.
//      -> sw_clean[0]=0 during reset.
//      -> full 6-edge latency restarts after rst_n rises.

Source files
------------

// File: rtl/switch_debouncer.sv
// Purpose: synchronises and debounces raw slide switches, one stability counter per bit.
// Latency: STABLE_CYCLES+2 edges from the first sampling edge to sw_clean; change pulses one cycle.
// Backpressure: none, free-running in the clk domain.
module switch_debouncer #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_changed,
    output logic             any_changed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] clean_nxt;
    logic [WIDTH-1:0] changed_nxt;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];

    // Any agreement between s2 and sw_clean discards the partial count.
    always_comb begin
        clean_nxt   = sw_clean;
        changed_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != sw_clean[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    clean_nxt[i]   = s2[i];
                    changed_nxt[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= '0;
            s2          <= '0;
            sw_clean    <= '0;
            sw_changed  <= '0;
            any_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1          <= sw_raw;
            s2          <= s1;
            sw_clean    <= clean_nxt;
            sw_changed  <= changed_nxt;
            any_changed <= |changed_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a window-based reference model checked every cycle.
module tb_switch_debouncer;

    localparam int WIDTH  = 8;
    localparam int STABLE = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_changed;
    logic             any_changed;

    int compared   = 0;
    int mismatched = 0;

    switch_debouncer #(
        .WIDTH(WIDTH),
        .STABLE_CYCLES(STABLE),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_raw(sw_raw),
        .sw_clean(sw_clean),
        .sw_changed(sw_changed),
        .any_changed(any_changed)
    );

    always #5 clk = ~clk;

    // Reference: a level is accepted once the last STABLE synchronised samples all differ from it.
    logic [WIDTH-1:0] m_s1 = '0;
    logic [WIDTH-1:0] m_s2 = '0;
    logic [WIDTH-1:0] m_clean = '0;
    logic [WIDTH-1:0] m_changed = '0;
    logic             m_any = 1'b0;
    logic [WIDTH-1:0] hist[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_changed = '0; m_any = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > STABLE) void'(hist.pop_front());
            m_changed = '0;
            if (hist.size() == STABLE) begin
                for (int b = 0; b < WIDTH; b++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    for (int j = 0; j < STABLE; j++)
                        if (hist[j][b] == m_clean[b]) all_diff = 1'b0;
                    if (all_diff) m_changed[b] = 1'b1;
                end
            end
            m_clean = m_clean ^ m_changed;
            m_any   = |m_changed;
            m_s2    = m_s1;
            m_s1    = sw_raw;
        end
    end

    always @(negedge clk) begin
        compared++;
        if (sw_clean !== m_clean || sw_changed !== m_changed || any_changed !== m_any) begin
            mismatched++;
            $display("FAIL model t=%0t: clean=%h changed=%h any=%b, required clean=%h changed=%h any=%b",
                     $time, sw_clean, sw_changed, any_changed, m_clean, m_changed, m_any);
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        sw_raw = '0;
        rst_n  = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
    endtask

    initial begin
        // 1. Reset with no clock edge yet
        rst_n  = 1'b0;
        sw_raw = 8'hFF;
        #1;
        check("reset_clean", sw_clean, 8'h00);
        check("reset_changed", sw_changed, 8'h00);
        check("reset_any", {7'b0, any_changed}, 8'h00);
        sw_raw = 8'h00;
        step(3);
        rst_n = 1'b1;
        step(2);

        // 2. Clean step on bit 0
        sw_raw = 8'h01;
        step(5);
        check("step_before", sw_clean, 8'h00);
        step(1);
        check("step_clean", sw_clean, 8'h01);
        check("step_changed", sw_changed, 8'h01);
        check("step_any", {7'b0, any_changed}, 8'h01);
        step(1);
        check("step_pulse_end", sw_changed, 8'h00);
        check("step_any_end", {7'b0, any_changed}, 8'h00);

        // 3. Bounce on bit 3
        sw_raw = 8'h09; step(3);
        sw_raw = 8'h01; step(1);
        sw_raw = 8'h09;
        step(5);
        check("bounce_before", sw_clean, 8'h01);
        step(1);
        check("bounce_clean", sw_clean, 8'h09);
        check("bounce_changed", sw_changed, 8'h08);
        step(1);
        check("bounce_pulse_end", sw_changed, 8'h00);

        // 4. Short glitch on bit 7
        reset_dut();
        sw_raw = 8'h80; step(3);
        sw_raw = 8'h00; step(12);
        check("glitch_clean", sw_clean, 8'h00);

        // 5. Simultaneous acceptance
        sw_raw = 8'hA5;
        step(5);
        check("simul_before", sw_clean, 8'h00);
        step(1);
        check("simul_clean", sw_clean, 8'hA5);
        check("simul_changed", sw_changed, 8'hA5);
        step(1);
        check("simul_pulse_end", sw_changed, 8'h00);

        // 6. Reset mid-count restarts the full latency
        reset_dut();
        sw_raw = 8'h01;
        step(2);
        rst_n = 1'b0;
        #1;
        check("midreset_clean", sw_clean, 8'h00);
        step(1);
        rst_n = 1'b1;
        step(5);
        check("midreset_before", sw_clean, 8'h00);
        step(1);
        check("midreset_clean_after", sw_clean, 8'h01);
        check("midreset_changed", sw_changed, 8'h01);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
